alu_div: RTL and testbench



---
 rtl/alu_div_pkg.sv | 26 ++
 rtl/alu_div_step.sv | 35 +++
 rtl/alu_div.sv | 189 ++++++++++++++++++
 tb/tb_alu_div.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/alu_div_pkg.sv
// alu_div_pkg: shared ALU divider definitions.
// Holds the datapath width, iteration count, FSM state encoding, the
// divide-by-zero result constants and a two's-complement negate helper.
package alu_div_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ITER_CNT = 32;
  localparam int unsigned CNT_W    = $clog2(ITER_CNT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Results reported when the divisor is zero.
  localparam logic [DATA_W-1:0] DIV0_QUOTIENT  = '0;
  localparam logic [DATA_W-1:0] DIV0_REMAINDER = '0;
  localparam logic              DIV0_EXCEPTION = 1'b1;

  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] x);
    return ~x + DATA_W'(1);
  endfunction

endpackage

// File: rtl/alu_div_step.sv
// alu_div_step: one combinational restoring-division iteration.
// Ports:
//   rem      - 33-bit partial remainder before this step
//   quo      - quotient/dividend shift register before this step
//   sub      - 33-bit two's-complement subtrahend (-divisor magnitude)
//   rem_next - partial remainder after this step
//   quo_next - shift register after this step (new quotient bit in [0])
module alu_div_step
  import alu_div_pkg::*;
(
  input  logic [DATA_W:0]   rem,
  input  logic [DATA_W-1:0] quo,
  input  logic [DATA_W:0]   sub,
  output logic [DATA_W:0]   rem_next,
  output logic [DATA_W-1:0] quo_next
);

  // One guard bit above the shifted remainder keeps the sign test exact
  // for any divisor magnitude up to 2^32-1.
  logic [DATA_W+1:0] rem_sh;
  logic [DATA_W+1:0] trial;

  always_comb begin
    rem_sh = {rem, quo[DATA_W-1]};
    trial  = rem_sh + {sub[DATA_W], sub};
    if (!trial[DATA_W+1]) begin
      rem_next = trial[DATA_W:0];
      quo_next = {quo[DATA_W-2:0], 1'b1};
    end else begin
      rem_next = rem_sh[DATA_W:0];
      quo_next = {quo[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/alu_div.sv
// alu_div: multi-cycle 32-bit restoring divider with start/ready handshake.
// Optional feature macro: ALU_DIV_SIGNED_EN (two's-complement operands).
// Ports:
//   clock, reset_n   - rising-edge clock, async active-low reset
//   in_start         - request, sampled only in IDLE
//   in_dividend      - dividend
//   in_divisor       - divisor
//   in_divisor_not   - bitwise NOT of in_divisor from the inverter stage
//   out_quotient     - quotient, held until replaced
//   out_remainder    - remainder, held until replaced
//   out_exception    - divide-by-zero flag
//   out_busy         - operation in progress (through FIX)
//   out_ready        - one-cycle completion pulse
module alu_div
  import alu_div_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_start,
  input  logic [DATA_W-1:0] in_dividend,
  input  logic [DATA_W-1:0] in_divisor,
  input  logic [DATA_W-1:0] in_divisor_not,
  output logic [DATA_W-1:0] out_quotient,
  output logic [DATA_W-1:0] out_remainder,
  output logic              out_exception,
  output logic              out_busy,
  output logic              out_ready
);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W:0]   sub_q, sub_d;
  logic [DATA_W-1:0] quotient_q, quotient_d;
  logic [DATA_W-1:0] remainder_q, remainder_d;
  logic              exception_q, exception_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;

  logic [DATA_W:0]   step_rem;
  logic [DATA_W-1:0] step_quo;
  logic              div_zero;
  logic [DATA_W-1:0] dvd_mag;
  logic [DATA_W:0]   sub_new;
  logic [DATA_W-1:0] fix_quo;
  logic [DATA_W-1:0] fix_rem;

`ifdef ALU_DIV_SIGNED_EN
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic [DATA_W-1:0] dvs_mag;
`endif

  assign div_zero = (in_divisor == '0);

  // Operand preparation and result sign correction.
`ifdef ALU_DIV_SIGNED_EN
  always_comb begin
    dvd_mag = in_dividend[DATA_W-1] ? negate(in_dividend) : in_dividend;
    // The inverter stage already supplies ~divisor, so |divisor| of a
    // negative divisor is just in_divisor_not + 1.
    dvs_mag = in_divisor[DATA_W-1] ? (in_divisor_not + DATA_W'(1)) : in_divisor;
    sub_new = ~{1'b0, dvs_mag} + (DATA_W+1)'(1);
    fix_quo = neg_quo_q ? negate(quo_q) : quo_q;
    fix_rem = neg_rem_q ? negate(rem_q[DATA_W-1:0]) : rem_q[DATA_W-1:0];
  end
`else
  always_comb begin
    dvd_mag = in_dividend;
    // 33-bit -divisor: sign bit set above the inverted divisor, plus one.
    sub_new = {1'b1, in_divisor_not} + (DATA_W+1)'(1);
    fix_quo = quo_q;
    fix_rem = rem_q[DATA_W-1:0];
  end
`endif

  alu_div_step u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .sub      (sub_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    sub_d       = sub_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    exception_d = exception_q;
    busy_d      = busy_q;
    ready_d     = 1'b0;
`ifdef ALU_DIV_SIGNED_EN
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_start) begin
          if (div_zero) begin
            quotient_d  = DIV0_QUOTIENT;
            remainder_d = DIV0_REMAINDER;
            exception_d = DIV0_EXCEPTION;
            state_d     = DONE;
          end else begin
            rem_d   = '0;
            quo_d   = dvd_mag;
            sub_d   = sub_new;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = RUN;
`ifdef ALU_DIV_SIGNED_EN
            neg_quo_d = in_dividend[DATA_W-1] ^ in_divisor[DATA_W-1];
            neg_rem_d = in_dividend[DATA_W-1];
`endif
          end
        end
      end
      RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITER_CNT - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        quotient_d  = fix_quo;
        remainder_d = fix_rem;
        exception_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = DONE;
      end
      DONE: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      sub_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      exception_q <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
`ifdef ALU_DIV_SIGNED_EN
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      sub_q       <= sub_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      exception_q <= exception_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
`ifdef ALU_DIV_SIGNED_EN
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
`endif
    end
  end

  assign out_quotient  = quotient_q;
  assign out_remainder = remainder_q;
  assign out_exception = exception_q;
  assign out_busy      = busy_q;
  assign out_ready     = ready_q;

endmodule

// File: tb/tb_alu_div.sv
// tb_alu_div: self-checking bench for alu_div with a behavioural
// division model (native / and % on wide integers).
module tb_alu_div;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_start;
  logic [31:0] in_dividend;
  logic [31:0] in_divisor;
  logic [31:0] in_divisor_not;
  logic [31:0] out_quotient;
  logic [31:0] out_remainder;
  logic        out_exception;
  logic        out_busy;
  logic        out_ready;

  int errors = 0;
  int checks = 0;

  alu_div dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .in_start       (in_start),
    .in_dividend    (in_dividend),
    .in_divisor     (in_divisor),
    .in_divisor_not (in_divisor_not),
    .out_quotient   (out_quotient),
    .out_remainder  (out_remainder),
    .out_exception  (out_exception),
    .out_busy       (out_busy),
    .out_ready      (out_ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: truncating division, remainder follows the dividend sign.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic e);
    longint la, lb;
    if (b == 32'd0) begin
      q = 32'd0; r = 32'd0; e = 1'b1;
    end else begin
`ifdef ALU_DIV_SIGNED_EN
      la = longint'($signed(a));
      lb = longint'($signed(b));
`else
      la = longint'({32'd0, a});
      lb = longint'({32'd0, b});
`endif
      q = 32'(la / lb);
      r = 32'(la % lb);
      e = 1'b0;
    end
  endfunction

  // One divide; ign_at>0 pulses a 9/3 start mid-operation,
  // rst_at>0 asserts reset at that cycle and aborts.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input int ign_at, input int rst_at);
    logic [31:0] eq, er;
    logic        ee;
    int          lat;
    int          extra;
    int          watch;
    bit          aborted;
    model(a, b, eq, er, ee);
    @(negedge clock);
    in_start = 1'b1; in_dividend = a; in_divisor = b; in_divisor_not = ~b;
    lat = 0; aborted = 1'b0; extra = 0;
    for (int n = 0; n <= 60; n++) begin
      @(posedge clock); #1;
      if (n == 0) begin
        in_start = 1'b0;
        check("busy_after_start", 32'(out_busy), 32'(b != 32'd0));
      end
      if (ign_at > 0 && n == ign_at - 1) begin
        in_start = 1'b1; in_dividend = 32'd9; in_divisor = 32'd3; in_divisor_not = ~32'd3;
      end
      if (ign_at > 0 && n == ign_at) in_start = 1'b0;
      if (rst_at > 0 && n == rst_at) begin
        reset_n = 1'b0;
        #1;
        check("abort_quotient", out_quotient, 32'd0);
        check("abort_remainder", out_remainder, 32'd0);
        check("abort_exception", 32'(out_exception), 32'd0);
        check("abort_busy", 32'(out_busy), 32'd0);
        check("abort_ready", 32'(out_ready), 32'd0);
        aborted = 1'b1;
        break;
      end
      if (out_ready) begin
        lat = n;
        break;
      end
    end
    if (aborted) begin
      repeat (3) begin
        @(posedge clock); #1;
        if (out_ready) extra++;
      end
      check("ready_during_reset", 32'(extra), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      return;
    end
    check("latency", 32'(lat), (b == 32'd0) ? 32'd1 : 32'd34);
    check("quotient", out_quotient, eq);
    check("remainder", out_remainder, er);
    check("exception", 32'(out_exception), 32'(ee));
    watch = (ign_at > 0) ? 40 : 1;
    for (int n = 0; n < watch; n++) begin
      @(posedge clock); #1;
      if (out_ready) extra++;
    end
    check("no_extra_ready", 32'(extra), 32'd0);
    check("quotient_held", out_quotient, eq);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, b;
    int          sel;
    reset_n = 1'b0; in_start = 1'b0;
    in_dividend = '0; in_divisor = '0; in_divisor_not = '1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_quotient", out_quotient, 32'd0);
    check("rst_remainder", out_remainder, 32'd0);
    check("rst_exception", 32'(out_exception), 32'd0);
    check("rst_busy", 32'(out_busy), 32'd0);
    check("rst_ready", 32'(out_ready), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    run_div(32'd100, 32'd7, 0, 0);
    run_div(32'hFFFF_FFFF, 32'd1, 0, 0);
    run_div(32'd5, 32'd0, 0, 0);
    run_div(32'hFFFF_FFF9, 32'd2, 0, 0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_div(32'd100, 32'd7, 10, 0);
    run_div(32'd100, 32'd7, 0, 15);
    run_div(32'd9, 32'd3, 0, 0);

    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 9));
      a = $urandom;
      b = $urandom;
      case (sel)
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF;
        3: a = 32'h8000_0000;
        4: a = 32'($urandom_range(0, 20));
        5: b = b >> $urandom_range(1, 31);
        default: ;
      endcase
      run_div(a, b, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
